scoreboard_regfile: RTL and testbench
=====================================

Name: scoreboard_regfile

Overview:
- Parametrised successor to the integer register file.
- Provides NUM_READ asynchronous read ports and one synchronous writeback port.
- Tracks outstanding writers per register with a saturating pending counter, so several in-flight producers to one register are handled correctly.
- Raises a per-port and an aggregate RAW dependency flag, with optional writeback-to-read bypass.
- Sits between decode (reserve, read) and writeback (retire) in the pipeline.

Parameters:
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register data width.
- NUM_READ, 2, number of read ports (1..4).
- CNT_WIDTH, 2, width of each pending-writer counter; max outstanding = 2**CNT_WIDTH-1.
- SP_INDEX, 2, register loaded with stackptr on reset.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stackptr  in  DATA_WIDTH  reset value for register SP_INDEX; must be stable while reset is high.
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- rd_busy  out  NUM_READ  per-port RAW flag.
- raw_dependency  out  1  OR of rd_busy.
- reserve_valid  in  1  decode claims reserve_addr as a destination.
- reserve_addr  in  ADDR_WIDTH  destination being claimed.
- reserve_ready  out  1  low when reserve_addr's counter is saturated; a reserve is accepted only when reserve_valid && reserve_ready.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- flush  in  1  clears all pending counters (pipeline squash).
- write_complete  out  1  registered pulse, one cycle after any wb_valid.
- wb_underflow  out  1  sticky error flag.
- busy_vector  out  NUM_REGS  bit i = (pending counter i != 0).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - all registers 0, except reg[SP_INDEX] = stackptr;
  - all counters 0;
  - write_complete = 0, wb_underflow = 0.
  - After reset: busy_vector = 0, rd_busy = 0, raw_dependency = 0; rd_data reflects the reset register values.
- Register 0:
  - reads return 0 and never report busy;
  - writes and reserves to address 0 are ignored (reserve_ready = 1 for address 0);
  - counter 0 is never incremented.
- Reserve:
  - accepted reserve increments cnt[reserve_addr] at the next edge;
  - reserve_ready = (cnt[reserve_addr] != max) || (wb_valid && wb_addr == reserve_addr && cnt != 0);
  - reserve_ready is combinational.
- Writeback:
  - wb_valid && wb_addr != 0 writes wb_data at the next edge;
  - if cnt[wb_addr] > 0, it is decremented; if it is 0, cnt stays 0 and wb_underflow sets and holds until reset.
  - write_complete = registered wb_valid, including address 0.
- Simultaneous accepted reserve and writeback to the same address: data written, counter unchanged.
- Flush: all counters become 0 at the next edge.
  - Flush has priority over reserve and over writeback's decrement; a reserve in the same cycle is dropped.
  - Writeback data in the flush cycle is still written.
  - Underflow is not flagged in the flush cycle.
- Read port k (combinational):
  - If cnt[a] == 0: rd_data = reg[a], rd_busy = 0.
  - Else if BYPASS && wb_valid && wb_addr == a && cnt[a] == 1: rd_data = wb_data, rd_busy = 0.
  - Otherwise: rd_data = 0, rd_busy = 1.
  - A same-cycle reserve does not affect reads in that cycle; decode must order its own read before its reserve.
- Latency: reads 0 cycles; write, counter update and write_complete 1 cycle.

Test Plan:
- Reset with stackptr=0x8000_0000 -> rd_addr{2,5} gives rd_data{0x8000_0000,0}, busy_vector=0, raw_dependency=0; reset asserted mid-reserve clears cnt immediately without waiting for a clock edge.
- Reserve x5, next cycle read x5 -> rd_busy[0]=1, rd_data=0; wb x5=0x1234 with BYPASS=1 -> same-cycle rd_data=0x1234, rd_busy=0; next cycle busy_vector[5]=0, write_complete=1.
- Reserve x7 three times (CNT_WIDTH=2) -> reserve_ready=0 on the 4th attempt, cnt stays 3; one wb x7 -> still busy (cnt=2), read returns 0; two more wbs -> free, reg=last wb_data.
- Same-cycle reserve x9 and wb x9 with cnt=1 -> reg[9] written, cnt stays 1, x9 still busy; BYPASS=0 build -> the wb-cycle read of a cnt=1 register reports busy.
- Flush with x3,x4 busy plus simultaneous reserve x6 -> busy_vector=0 next cycle, x6 not reserved.
- wb x10 with cnt=0 -> reg[10] updated, wb_underflow=1 and held; wb/reserve/read x0 -> reads 0, never busy, busy_vector[0]=0.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// Integer register file with per-register pending-writer scoreboard.
// Asynchronous reads with RAW detection and optional writeback forwarding.
module scoreboard_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_READ   = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int SP_INDEX   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [DATA_WIDTH-1:0]          stackptr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_READ-1:0]            rd_busy_o,
  output logic                           raw_dependency_o,
  input  logic                           reserve_valid_i,
  input  logic [ADDR_WIDTH-1:0]          reserve_addr_i,
  output logic                           reserve_ready_o,
  input  logic                           wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]          wb_addr_i,
  input  logic [DATA_WIDTH-1:0]          wb_data_i,
  input  logic                           flush_i,
  output logic                           write_complete_o,
  output logic                           wb_underflow_o,
  output logic [2**ADDR_WIDTH-1:0]       busy_vector_o
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d  [NUM_REGS];
  logic                  write_complete_q;
  logic                  wb_underflow_q;
  logic                  wb_underflow_d;

  logic                  wb_en;
  logic [CNT_WIDTH-1:0]  wb_cnt;
  logic [CNT_WIDTH-1:0]  rsv_cnt;
  logic                  rsv_accept;
  logic                  rsv_wb_pair;

  assign wb_en   = wb_valid_i && (wb_addr_i != '0);
  assign wb_cnt  = cnt_q[wb_addr_i];
  assign rsv_cnt = cnt_q[reserve_addr_i];

  // A saturated counter can still accept when a retire to it lands this cycle.
  assign reserve_ready_o = (rsv_cnt != CNT_MAX) ||
                           (wb_valid_i && (wb_addr_i == reserve_addr_i) && (rsv_cnt != '0));
  assign rsv_accept  = reserve_valid_i && reserve_ready_o && (reserve_addr_i != '0);
  assign rsv_wb_pair = rsv_accept && wb_valid_i && (wb_addr_i == reserve_addr_i);

  assign wb_underflow_d = wb_underflow_q || (wb_en && (wb_cnt == '0) && !flush_i);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic inc;
      logic dec;
      assign inc = rsv_accept && (reserve_addr_i == ADDR_WIDTH'(gi)) && !rsv_wb_pair;
      assign dec = wb_en && (wb_addr_i == ADDR_WIDTH'(gi)) && (cnt_q[gi] != '0) && !rsv_wb_pair;
      assign cnt_d[gi] = flush_i ? '0 :
                         inc     ? cnt_q[gi] + CNT_WIDTH'(1) :
                         dec     ? cnt_q[gi] - CNT_WIDTH'(1) :
                                   cnt_q[gi];
      assign regs_d[gi] = (wb_en && (wb_addr_i == ADDR_WIDTH'(gi))) ? wb_data_i : regs_q[gi];
      assign busy_vector_o[gi] = (cnt_q[gi] != '0);
    end

    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [CNT_WIDTH-1:0]  cnt;
      logic                  fwd;
      assign addr = rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign cnt  = cnt_q[addr];
      // Only the last outstanding producer retiring now makes the value final.
      assign fwd  = (BYPASS != 0) && wb_valid_i && (wb_addr_i == addr) && (cnt == CNT_WIDTH'(1));
      assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
          (addr == '0) ? '0 :
          (cnt == '0)  ? regs_q[addr] :
          fwd          ? wb_data_i : '0;
      assign rd_busy_o[gi] = (addr != '0) && (cnt != '0) && !fwd;
    end
  endgenerate

  assign raw_dependency_o = |rd_busy_o;
  assign write_complete_o = write_complete_q;
  assign wb_underflow_o   = wb_underflow_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ((i == SP_INDEX) && (i != 0)) ? stackptr_i : '0;
        cnt_q[i]  <= '0;
      end
      write_complete_q <= 1'b0;
      wb_underflow_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      write_complete_q <= wb_valid_i;
      wb_underflow_q   <= wb_underflow_d;
    end
  end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: BYPASS=1 and BYPASS=0 instances driven in
// lockstep and compared against an array-based model of the scoreboard rules.
module tb_scoreboard_regfile;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int SP = 2;
  localparam int NREGS = 32;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [DW-1:0]    stackptr;
  logic [NR*AW-1:0] rd_addr;
  logic             rv, wv, flush;
  logic [AW-1:0]    ra, wa;
  logic [DW-1:0]    wd;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             raw_b, raw_n, rdy_b, rdy_n, wc_b, wc_n, uf_b, uf_n;
  logic [NREGS-1:0] bv_b, bv_n;

  scoreboard_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .CNT_WIDTH(CW),
                       .SP_INDEX(SP), .BYPASS(1)) dut (
    .clk_i(clk), .reset_i(reset), .stackptr_i(stackptr), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b), .raw_dependency_o(raw_b),
    .reserve_valid_i(rv), .reserve_addr_i(ra), .reserve_ready_o(rdy_b),
    .wb_valid_i(wv), .wb_addr_i(wa), .wb_data_i(wd), .flush_i(flush),
    .write_complete_o(wc_b), .wb_underflow_o(uf_b), .busy_vector_o(bv_b));

  scoreboard_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .CNT_WIDTH(CW),
                       .SP_INDEX(SP), .BYPASS(0)) dut_nb (
    .clk_i(clk), .reset_i(reset), .stackptr_i(stackptr), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n), .raw_dependency_o(raw_n),
    .reserve_valid_i(rv), .reserve_addr_i(ra), .reserve_ready_o(rdy_n),
    .wb_valid_i(wv), .wb_addr_i(wa), .wb_data_i(wd), .flush_i(flush),
    .write_complete_o(wc_n), .wb_underflow_o(uf_n), .busy_vector_o(bv_n));

  logic [DW-1:0] mreg [NREGS];
  int            mcnt [NREGS];
  bit            muf, mwc;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mreg[i] = '0;
      mcnt[i] = 0;
    end
    mreg[SP] = stackptr;
    muf = 0;
    mwc = 0;
  endtask

  function automatic bit model_ready();
    return (mcnt[ra] != CMAX) || (wv && (wa == ra) && (mcnt[ra] != 0));
  endfunction

  task automatic check_comb();
    logic [AW-1:0] a;
    logic [DW-1:0] ed_b, ed_n;
    bit eb_b, eb_n, any_b, any_n;
    any_b = 0;
    any_n = 0;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      if (a == 0 || mcnt[a] == 0) begin
        ed_b = (a == 0) ? '0 : mreg[a];
        ed_n = ed_b;
        eb_b = 0;
        eb_n = 0;
      end else if (wv && wa == a && mcnt[a] == 1) begin
        ed_b = wd;   eb_b = 0;
        ed_n = '0;   eb_n = 1;
      end else begin
        ed_b = '0;   eb_b = 1;
        ed_n = '0;   eb_n = 1;
      end
      any_b |= eb_b;
      any_n |= eb_n;
      chk($sformatf("rd_data%0d_byp a=%0d", k, a), rd_data_b[k*DW +: DW], ed_b);
      chk($sformatf("rd_busy%0d_byp a=%0d", k, a), DW'(rd_busy_b[k]), DW'(eb_b));
      chk($sformatf("rd_data%0d_nobyp a=%0d", k, a), rd_data_n[k*DW +: DW], ed_n);
      chk($sformatf("rd_busy%0d_nobyp a=%0d", k, a), DW'(rd_busy_n[k]), DW'(eb_n));
    end
    chk("raw_dependency_byp", DW'(raw_b), DW'(any_b));
    chk("raw_dependency_nobyp", DW'(raw_n), DW'(any_n));
    chk($sformatf("reserve_ready_byp a=%0d", ra), DW'(rdy_b), DW'(model_ready()));
    chk($sformatf("reserve_ready_nobyp a=%0d", ra), DW'(rdy_n), DW'(model_ready()));
  endtask

  task automatic model_step();
    bit acc;
    acc = rv && model_ready() && (ra != 0);
    if (flush) begin
      for (int i = 0; i < NREGS; i++) mcnt[i] = 0;
    end else begin
      if (wv && wa != 0 && mcnt[wa] == 0) muf = 1;
      if (!(acc && wv && wa == ra)) begin
        if (wv && wa != 0 && mcnt[wa] > 0) mcnt[wa]--;
        if (acc) mcnt[ra]++;
      end
    end
    if (wv && wa != 0) mreg[wa] = wd;
    mwc = wv;
  endtask

  task automatic check_seq();
    logic [NREGS-1:0] ebv;
    for (int i = 0; i < NREGS; i++) ebv[i] = (mcnt[i] != 0);
    chk("busy_vector_byp", DW'(bv_b), DW'(ebv));
    chk("busy_vector_nobyp", DW'(bv_n), DW'(ebv));
    chk("write_complete_byp", DW'(wc_b), DW'(mwc));
    chk("write_complete_nobyp", DW'(wc_n), DW'(mwc));
    chk("wb_underflow_byp", DW'(uf_b), DW'(muf));
    chk("wb_underflow_nobyp", DW'(uf_n), DW'(muf));
  endtask

  task automatic run_cycle();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_seq();
  endtask

  task automatic idle();
    rv = 0;
    wv = 0;
    flush = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Reset is asserted between clock edges, so the checks right after it
  // observe the asynchronous clear before any edge arrives.
  task automatic do_reset(input logic [DW-1:0] sp);
    stackptr = sp;
    reset = 1;
    model_reset();
    #1;
    check_comb();
    check_seq();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 0;
    idle();
    ra = '0; wa = '0; wd = '0;
    stackptr = '0;
    set_rd(2, 5);
    #2;
    do_reset(64'h8000_0000);
    run_cycle();

    // reserve x5, read busy, retire with forwarding
    rv = 1; ra = 5; run_cycle();
    idle(); set_rd(5, 2); run_cycle();
    wv = 1; wa = 5; wd = 64'h1234; run_cycle();
    idle(); run_cycle();

    // saturate x7, then drain it
    set_rd(7, 0);
    rv = 1; ra = 7; repeat (4) run_cycle();
    idle(); wv = 1; wa = 7; wd = 64'hAAAA; run_cycle();
    wv = 0; run_cycle();
    wv = 1; wd = 64'hBBBB; run_cycle();
    wd = 64'hCCCC; run_cycle();
    idle(); run_cycle();

    // same-cycle reserve and retire on x9
    rv = 1; ra = 9; run_cycle();
    idle(); set_rd(9, 9);
    rv = 1; ra = 9; wv = 1; wa = 9; wd = 64'h9999; run_cycle();
    idle(); run_cycle();
    wv = 1; wa = 9; wd = 64'h9A9A; run_cycle();
    idle(); run_cycle();

    // flush drops a concurrent reserve
    rv = 1; ra = 3; run_cycle();
    ra = 4; run_cycle();
    ra = 6; flush = 1; set_rd(3, 6); run_cycle();
    idle(); run_cycle();

    // underflow on x10, sticky
    wv = 1; wa = 10; wd = 64'h1010; set_rd(10, 0); run_cycle();
    idle(); run_cycle(); run_cycle();

    // register 0 traffic
    wv = 1; wa = 0; wd = 64'hFFFF; rv = 1; ra = 0; set_rd(0, 0); run_cycle();
    idle(); run_cycle();

    // reset mid-reserve
    rv = 1; ra = 12; set_rd(12, 2); run_cycle();
    #2;
    do_reset(stackptr);
    idle(); run_cycle();

    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 50) begin
        idle();
        do_reset({$urandom(), $urandom()});
      end
      rv    = 1'($urandom_range(0, 1));
      ra    = AW'($urandom_range(0, 11));
      wv    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, 11));
      wd    = {$urandom(), $urandom()};
      flush = ($urandom_range(0, 15) == 0);
      set_rd(AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11)));
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
